transpose_io_ctrl: RTL and testbench
====================================

TRANSPOSE_IO_CTRL -- requirements
Module: transpose_io_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, element width carried per line lane.
REQ-002 SHALL have parameter LINE_WIDTH, default 512, line width (32 lanes x DATA_WIDTH).
REQ-003 SHALL have parameter MATRIX_LINES, default 32, lines per matrix.
REQ-004 SHALL have parameter CNT_W, default 16, width of the matrix-count field.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port cfg_start, input, 1, one-cycle job start pulse.
REQ-008 SHALL have port cfg_num_matrices, input, CNT_W, matrices in the job; sampled on the accepted cfg_start.
REQ-009 SHALL have port busy, output, 1, high while a job is active.
REQ-010 SHALL have port done, output, 1, one-cycle pulse at job end.
REQ-011 SHALL have port src_valid / src_ready / src_data, in / out / in, 1 / 1 / LINE_WIDTH, upstream line stream.
REQ-012 SHALL have port afu_din / afu_we / afu_full, out / out / in, LINE_WIDTH / 1 / 1, transpose-engine input FIFO write side.
REQ-013 SHALL have port afu_dout / afu_re / afu_empty, in / out / in, LINE_WIDTH / 1 / 1, transpose-engine output FIFO read side; synchronous read, data valid the cycle after afu_re.
REQ-014 SHALL have port dst_valid / dst_ready / dst_data, out / in / out, 1 / 1 / LINE_WIDTH, downstream line stream.
REQ-015 SHALL have port stall_cycles, output, 32, performance counter (see Configuration).

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DRAIN -> FINISH -> IDLE.
REQ-017 IDLE: cfg_start with cfg_num_matrices>0 -> RUN; with cfg_num_matrices==0 -> FINISH; cfg_start outside IDLE ignored.
REQ-018 SHALL latch total = cfg_num_matrices*MATRIX_LINES (CNT_W+5 bits, no overflow) on the accepted start.
REQ-019 Write path: src_ready = (state==RUN) & ~afu_full & (sent<total); afu_we = src_valid & src_ready; afu_din = src_data; sent increments per afu_we.
REQ-020 RUN -> DRAIN in the cycle sent reaches total.
REQ-021 Read path: afu_re = busy & ~afu_empty & (slots_free>=2, counting in-flight read); afu_dout captured the next cycle into a 2-entry output buffer.
REQ-022 dst_valid high whenever buffer non-empty; dst_data = oldest entry; entry retires on dst_valid & dst_ready; order preserved; no line dropped or duplicated under any dst_ready pattern.
REQ-023 recv increments per retired dst line; DRAIN -> FINISH when recv reaches total.
REQ-024 FINISH: done=1 for exactly one cycle, then IDLE; busy=1 in RUN, DRAIN, FINISH.
REQ-025 Simultaneous buffer push and pop in one cycle SHALL be supported without bubble; sustained throughput one line/cycle both directions when unstalled.
REQ-026 Lines appearing on afu side while IDLE SHALL NOT be read (afu_re=0).

Reset
REQ-027 On reset low: state=IDLE, sent=recv=0, buffer empty, busy=done=src_ready=afu_we=afu_re=dst_valid=0, stall_cycles=0, afu_din/dst_data=0.
REQ-028 Reset mid-job SHALL abort immediately; in-flight read data discarded; no done pulse.

Configuration
REQ-029 With TRANSPOSE_IO_CTRL_PERF_EN defined: stall_cycles counts cycles busy with (src_valid & ~src_ready in RUN) or (dst_valid & ~dst_ready), saturating at 2^32-1, cleared on accepted start.
REQ-030 Without TRANSPOSE_IO_CTRL_PERF_EN: stall_cycles tied to 0, no counter logic.

Structure
REQ-031 Shared package transpose_pkg SHALL hold FSM state enum, MATRIX_LINES and LINE_WIDTH constants.
REQ-032 Output buffer SHALL be a sub-module transpose_skid_buf (2-entry, valid/ready).

Verification
REQ-033 cfg_num_matrices=1, src and dst always ready, afu loopback -> 32 afu_we, 32 dst lines in order, done once, busy low after.
REQ-034 cfg_num_matrices=0 -> done pulse one cycle after start, no afu_we/afu_re.
REQ-035 cfg_num_matrices=2, afu_full asserted 10 cycles mid-job -> src_ready low those cycles, 64 lines total, no loss.
REQ-036 dst_ready random 50% -> dst sequence equals afu_dout sequence exactly, buffer never overflows.
REQ-037 reset low at line 17 of 32 -> all outputs zero next cycle, no done; new job of 1 matrix completes normally.
REQ-038 PERF_EN build, dst_ready low 5 cycles with dst_valid high -> stall_cycles==5.

Source files
------------

// File: rtl/transpose_pkg.sv
// rtl/transpose_pkg.sv - shared FSM state type and line geometry for the transpose I/O controller
package transpose_pkg;

    localparam int TP_LANES        = 32;
    localparam int TP_MATRIX_LINES = 32;
    localparam int TP_LINE_WIDTH   = TP_LANES * 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/transpose_skid_buf.sv
// rtl/transpose_skid_buf.sv - 2-entry valid/ready output buffer between the afu read port and dst
module transpose_skid_buf
    import transpose_pkg::*;
#(
    parameter int WIDTH = TP_LINE_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             pop;

    // The producer only pushes when a slot is guaranteed, so no in_ready is needed.
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (in_valid) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({in_valid, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/transpose_io_ctrl.sv
// rtl/transpose_io_ctrl.sv - job-level line mover between src, the transpose engine FIFOs and dst
// Optional stall counter enabled by TRANSPOSE_IO_CTRL_PERF_EN.
module transpose_io_ctrl
    import transpose_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int LINE_WIDTH   = TP_LANES * DATA_WIDTH,
    parameter int MATRIX_LINES = TP_MATRIX_LINES,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_start,
    input  logic [CNT_W-1:0]      cfg_num_matrices,
    output logic                  busy,
    output logic                  done,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic [LINE_WIDTH-1:0] src_data,
    output logic [LINE_WIDTH-1:0] afu_din,
    output logic                  afu_we,
    input  logic                  afu_full,
    input  logic [LINE_WIDTH-1:0] afu_dout,
    output logic                  afu_re,
    input  logic                  afu_empty,
    output logic                  dst_valid,
    input  logic                  dst_ready,
    output logic [LINE_WIDTH-1:0] dst_data,
    output logic [31:0]           stall_cycles
);

    localparam int TOT_W = CNT_W + 5;

    state_t           state;
    state_t           state_nx;
    logic [TOT_W-1:0] total;
    logic [TOT_W-1:0] total_calc;
    logic [TOT_W-1:0] sent;
    logic [TOT_W-1:0] recv;
    logic             start_ok;
    logic             rd_inflight;
    logic             pop;
    logic [1:0]       buf_count;
    logic [1:0]       slots_free;
    logic [1:0]       slots_need;

    assign start_ok   = (state == ST_IDLE) && cfg_start;
    assign total_calc = TOT_W'(cfg_num_matrices) * TOT_W'(MATRIX_LINES);

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_FINISH);
    assign src_ready = (state == ST_RUN) && !afu_full && (sent < total);
    assign afu_we    = src_valid && src_ready;
    assign afu_din   = (state == ST_RUN) ? src_data : '0;

    // A new read needs its own slot plus one more if a read is already landing next cycle.
    assign pop        = dst_valid && dst_ready;
    assign slots_free = 2'd2 - buf_count + {1'b0, pop};
    assign slots_need = rd_inflight ? 2'd2 : 2'd1;
    assign afu_re     = busy && !afu_empty && (slots_free >= slots_need);

    transpose_skid_buf #(
        .WIDTH(LINE_WIDTH)
    ) u_obuf (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_inflight),
        .in_data   (afu_dout),
        .out_valid (dst_valid),
        .out_data  (dst_data),
        .out_ready (dst_ready),
        .count     (buf_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            total       <= '0;
            sent        <= '0;
            recv        <= '0;
            rd_inflight <= 1'b0;
        end else begin
            state       <= state_nx;
            rd_inflight <= afu_re;
            if (start_ok) begin
                total <= total_calc;
                sent  <= '0;
                recv  <= '0;
            end else begin
                if (afu_we) sent <= sent + TOT_W'(1);
                if (pop)    recv <= recv + TOT_W'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_nx = (cfg_num_matrices != '0) ? ST_RUN : ST_FINISH;
                end
            end
            ST_RUN: begin
                if (afu_we && (sent + TOT_W'(1) == total)) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (recv == total) state_nx = ST_FINISH;
            end
            ST_FINISH: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

`ifdef TRANSPOSE_IO_CTRL_PERF_EN
    logic [31:0] stall_q;
    logic        stall_hit;

    assign stall_hit = busy && (((state == ST_RUN) && src_valid && !src_ready) ||
                                (dst_valid && !dst_ready));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (start_ok) begin
            stall_q <= '0;
        end else if (stall_hit && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_transpose_io_ctrl.sv
// tb/tb_transpose_io_ctrl.sv - directed self-checking bench for transpose_io_ctrl with an afu loopback FIFO
module tb_transpose_io_ctrl;

    localparam int LW = 512;
    localparam int ML = 32;
    localparam int CW = 16;
`ifdef TRANSPOSE_IO_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic [CW-1:0] cfg_num = '0;
    logic          busy;
    logic          done;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [LW-1:0] src_data = '0;
    logic [LW-1:0] afu_din;
    logic          afu_we;
    logic          afu_full;
    logic [LW-1:0] afu_dout = '0;
    logic          afu_re;
    logic          afu_empty;
    logic          dst_valid;
    logic          dst_ready = 1'b0;
    logic [LW-1:0] dst_data;
    logic [31:0]   stall_cycles;

    int n_vec = 0;
    int n_err = 0;

    logic [LW-1:0] afu_mem [256];
    logic [7:0]    wp = '0;
    logic [7:0]    rp = '0;
    logic          force_full = 1'b0;
    logic          inj = 1'b0;
    logic          afu_flush = 1'b0;
    logic [LW-1:0] inj_data = '0;

    always #5 clk = ~clk;

    transpose_io_ctrl dut (
        .clk              (clk),
        .reset            (rst_n),
        .cfg_start        (cfg_start),
        .cfg_num_matrices (cfg_num),
        .busy             (busy),
        .done             (done),
        .src_valid        (src_valid),
        .src_ready        (src_ready),
        .src_data         (src_data),
        .afu_din          (afu_din),
        .afu_we           (afu_we),
        .afu_full         (afu_full),
        .afu_dout         (afu_dout),
        .afu_re           (afu_re),
        .afu_empty        (afu_empty),
        .dst_valid        (dst_valid),
        .dst_ready        (dst_ready),
        .dst_data         (dst_data),
        .stall_cycles     (stall_cycles)
    );

    // Loopback transpose engine: a deep FIFO with a one-cycle synchronous read.
    assign afu_empty = (wp == rp);
    assign afu_full  = force_full || (8'(wp - rp) >= 8'd200);

    always @(posedge clk) begin
        if (!rst_n || afu_flush) begin
            rp <= wp;
        end else begin
            if (afu_we) begin
                afu_mem[wp] <= afu_din;
                wp          <= wp + 8'd1;
            end else if (inj) begin
                afu_mem[wp] <= inj_data;
                wp          <= wp + 8'd1;
            end
            if (afu_re) begin
                afu_dout <= afu_mem[rp];
                rp       <= rp + 8'd1;
            end
        end
    end

    function automatic logic [LW-1:0] line_val(input int tag, input int idx);
        logic [31:0] w;
        w = 32'(tag * 4096 + idx);
        return {16{w}};
    endfunction

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},      LW'(busy),         '0);
        chk({tag, "_done"},      LW'(done),         '0);
        chk({tag, "_src_ready"}, LW'(src_ready),    '0);
        chk({tag, "_afu_we"},    LW'(afu_we),       '0);
        chk({tag, "_afu_re"},    LW'(afu_re),       '0);
        chk({tag, "_dst_valid"}, LW'(dst_valid),    '0);
        chk({tag, "_stall"},     LW'(stall_cycles), '0);
        chk({tag, "_afu_din"},   afu_din,           '0);
        chk({tag, "_dst_data"},  dst_data,          '0);
    endtask

    // mode 0: dst always ready; 1: random dst_ready plus an ignored mid-job start; 2: one 5-cycle dst pause
    task automatic run_job(input int tag, input int n, input int mode, input int full_at,
                           input int full_len, input int abort_at, input longint exp_stall);
        int total, sent, got, we_cnt, re_cnt, pause_left, finished, gap;
        bit paused;
        total = n * ML; sent = 0; got = 0; we_cnt = 0; re_cnt = 0;
        pause_left = 0; finished = 0; gap = 0; paused = 1'b0;
        @(negedge clk);
        cfg_start = 1'b1; cfg_num = CW'(n); src_valid = 1'b0; dst_ready = 1'b1;
        for (int cyc = 0; cyc < 3000 && finished == 0; cyc++) begin
            @(negedge clk);
            cfg_start  = 1'b0;
            src_valid  = (sent < total);
            src_data   = line_val(tag, sent);
            force_full = (cyc >= full_at) && (cyc < full_at + full_len);
            if (mode == 1) begin
                dst_ready = 1'($urandom_range(0, 1));
                if (cyc == 5) begin
                    cfg_start = 1'b1;
                    cfg_num   = CW'(7);
                end
            end else if (mode == 2) begin
                if (!paused && got >= 4 && dst_valid) begin
                    paused = 1'b1; pause_left = 5;
                end
                dst_ready = (pause_left == 0);
                if (pause_left > 0) pause_left--;
            end else begin
                dst_ready = 1'b1;
            end
            #1;
            if (force_full) chk("src_ready_while_full", LW'(src_ready), '0);
            if (afu_we) begin sent++; we_cnt++; end
            if (afu_re) re_cnt++;
            if (got > 0 && got < total && !dst_valid) gap++;
            if (dst_valid && dst_ready) begin
                chk("dst_line", dst_data, line_val(tag, got));
                got++;
            end
            if (done) finished = 1;
            if (abort_at > 0 && sent == abort_at) return;
        end
        force_full = 1'b0;
        src_valid  = 1'b0;
        chk("job_finished",  LW'(finished), LW'(1));
        chk("afu_we_count",  LW'(we_cnt),   LW'(total));
        chk("afu_re_count",  LW'(re_cnt),   LW'(total));
        chk("dst_count",     LW'(got),      LW'(total));
        if (mode == 0 && full_len == 0) chk("dst_no_bubble", LW'(gap), '0);
        @(negedge clk); #1;
        chk("done_single",   LW'(done),     '0);
        chk("busy_after",    LW'(busy),     '0);
        if (exp_stall >= 0) chk("stall_cycles", LW'(stall_cycles), LW'(exp_stall));
    endtask

    initial begin
        // Reset state with live-looking inputs
        src_valid = 1'b1;
        src_data  = line_val(9, 9);
        dst_ready = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1; src_valid = 1'b0;

        // Lines sitting in the engine while IDLE are never read
        @(negedge clk); inj = 1'b1; inj_data = line_val(15, 1);
        @(negedge clk); inj_data = line_val(15, 2);
        @(negedge clk); inj = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; chk("idle_no_read", LW'(afu_re), '0);
            @(negedge clk);
        end
        afu_flush = 1'b1;
        @(negedge clk); afu_flush = 1'b0;

        run_job(1, 1, 0, 10000, 0, 0, 0);

        // Zero-matrix job finishes without touching the engine
        @(negedge clk); cfg_start = 1'b1; cfg_num = '0;
        @(negedge clk); cfg_start = 1'b0; #1;
        chk("zero_done",   LW'(done),   LW'(1));
        chk("zero_busy",   LW'(busy),   LW'(1));
        chk("zero_afu_we", LW'(afu_we), '0);
        chk("zero_afu_re", LW'(afu_re), '0);
        @(negedge clk); #1;
        chk("zero_done_end", LW'(done), '0);
        chk("zero_busy_end", LW'(busy), '0);

        run_job(2, 2, 0, 10, 10, 0, PERF ? 10 : 0);
        run_job(3, 2, 1, 10000, 0, 0, -1);

        // Abort after line 17, then a clean job
        run_job(4, 1, 0, 10000, 0, 17, -1);
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        chk_all_zero("abort_now");
        @(negedge clk); #1;
        chk_all_zero("abort_next");
        @(negedge clk);
        rst_n = 1'b1; src_valid = 1'b0;
        run_job(5, 1, 0, 10000, 0, 0, 0);

        run_job(6, 1, 2, 10000, 0, 0, PERF ? 5 : 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
